// File: rtl/bsg_credit_gated_sender.sv
// Credit-gated link sender: buffers producer flits and launches one per cycle
// while the upstream credit counter reports credit, pulsing a decrement per launch.
module bsg_credit_gated_sender #(
   parameter int unsigned width_p           = 32,
   parameter int unsigned els_p             = 4,
   parameter int unsigned stall_ctr_width_p = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [width_p-1:0]           data_i,
   input  logic                         v_i,
   output logic                         ready_o,
   input  logic                         credits_avail_i,
   output logic                         dec_credit_o,
   output logic                         v_o,
   output logic [width_p-1:0]           data_o,
   output logic                         empty_o,
   output logic [stall_ctr_width_p-1:0] stall_cnt_o
);

   localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;

   logic [ptr_width_lp-1:0]      wptr_q, rptr_q;
   logic [width_p-1:0]           mem_q [els_p];
   logic [width_p-1:0]           data_q;
   logic                         v_q;
   logic [stall_ctr_width_p-1:0] stall_cnt_q;

   logic full, empty, enq, launch;

   // Extra MSB on the pointers separates full from empty when low bits match.
   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[ptr_width_lp-2:0] == rptr_q[ptr_width_lp-2:0])
                 & (wptr_q[ptr_width_lp-1] != rptr_q[ptr_width_lp-1]);

   assign ready_o      = ~full & ~reset_i;
   assign enq          = v_i & ready_o;
   assign launch       = ~empty & credits_avail_i & ~reset_i;
   assign dec_credit_o = launch;
   assign empty_o      = empty;
   assign v_o          = v_q;
   assign data_o       = data_q;
   assign stall_cnt_o  = stall_cnt_q;

   // Storage is not reset; only the pointers define which entries are live.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wptr_q[ptr_width_lp-2:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         v_q         <= 1'b0;
         data_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (enq) begin
            wptr_q <= wptr_q + ptr_width_lp'(1);
         end
         if (launch) begin
            rptr_q <= rptr_q + ptr_width_lp'(1);
            data_q <= mem_q[rptr_q[ptr_width_lp-2:0]];
         end
         v_q <= launch;
         if (~empty & ~credits_avail_i & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + stall_ctr_width_p'(1);
         end
      end
   end

endmodule

// File: tb/tb_bsg_credit_gated_sender.sv
// Directed bench for bsg_credit_gated_sender with a queue-based output scoreboard.
module tb_bsg_credit_gated_sender;

   localparam int unsigned width_lp = 32;
   localparam int unsigned stall_w_lp = 4;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic [width_lp-1:0]   data_i;
   logic                  v_i;
   logic                  ready_o;
   logic                  credits_avail_i;
   logic                  dec_credit_o;
   logic                  v_o;
   logic [width_lp-1:0]   data_o;
   logic                  empty_o;
   logic [stall_w_lp-1:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;
   int dcnt = 0;
   int vcnt = 0;
   logic prev_dec = 1'b0;
   logic [width_lp-1:0] sb [$];

   bsg_credit_gated_sender #(
      .width_p          (width_lp),
      .els_p            (4),
      .stall_ctr_width_p(stall_w_lp)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .data_i         (data_i),
      .v_i            (v_i),
      .ready_o        (ready_o),
      .credits_avail_i(credits_avail_i),
      .dec_credit_o   (dec_credit_o),
      .v_o            (v_o),
      .data_o         (data_o),
      .empty_o        (empty_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: compares link output against the scoreboard, then records new enqueues.
   always @(negedge clk_i) begin
      if (reset_i) begin
         sb.delete();
         prev_dec = 1'b0;
      end else begin
         if (v_o) begin
            vcnt++;
            checks++;
            if (!prev_dec) begin
               errors++;
               $display("FAIL v_without_dec: v_o=1 but dec_credit_o was 0 last cycle at %0t", $time);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_flit: got 0x%0h expected no flit at %0t", data_o, $time);
            end else begin
               logic [width_lp-1:0] exp;
               exp = sb.pop_front();
               if (data_o !== exp) begin
                  errors++;
                  $display("FAIL flit_data: got 0x%0h expected 0x%0h at %0t", data_o, exp, $time);
               end
            end
         end
         if (dec_credit_o) dcnt++;
         prev_dec = dec_credit_o;
         if (v_i && ready_o) sb.push_back(data_i);
      end
   end

   initial begin
      int d0, v0;
      reset_i = 1'b1;
      v_i = 1'b0;
      data_i = '0;
      credits_avail_i = 1'b1;
      #3;
      check("rst_ready", ready_o, 0);
      check("rst_dec", dec_credit_o, 0);
      check("rst_v", v_o, 0);
      check("rst_data", data_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_stall", stall_cnt_o, 0);
      tick();
      tick();
      reset_i = 1'b0;

      // Idle with credit: nothing launches.
      repeat (3) tick();
      check("idle_v", v_o, 0);
      check("idle_dec", dec_credit_o, 0);
      check("idle_empty", empty_o, 1);
      check("idle_stall", stall_cnt_o, 0);
      check("idle_ready", ready_o, 1);

      // Single flit latency.
      v_i = 1'b1;
      data_i = 32'hA5A5_0001;
      tick();
      v_i = 1'b0;
      #1;
      check("single_dec_t1", dec_credit_o, 1);
      check("single_v_t1", v_o, 0);
      tick();
      check("single_v_t2", v_o, 1);
      check("single_data_t2", data_o, 32'hA5A5_0001);
      check("single_dec_t2", dec_credit_o, 0);
      tick();
      check("single_v_t3", v_o, 0);

      // Fill with no credit, observe stall counting, then drain.
      credits_avail_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v_i = 1'b1;
         data_i = 32'h10 + i;
         tick();
      end
      v_i = 1'b0;
      check("full_ready", ready_o, 0);
      check("full_empty", empty_o, 0);
      check("stall_3", stall_cnt_o, 3);
      check("full_dec", dec_credit_o, 0);
      tick();
      check("stall_4", stall_cnt_o, 4);
      credits_avail_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("drain_dec", dec_credit_o, 1);
         tick();
      end
      check("drain_dec_done", dec_credit_o, 0);
      check("drain_empty", empty_o, 1);
      check("drain_ready", ready_o, 1);
      tick();
      tick();

      // Streaming: 16 flits back to back, two pointer wraps.
      d0 = dcnt;
      v0 = vcnt;
      for (int i = 0; i < 16; i++) begin
         v_i = 1'b1;
         data_i = 32'h100 + i;
         tick();
         check("stream_ready", ready_o, 1);
         if (i >= 2) check("stream_v", v_o, 1);
      end
      v_i = 1'b0;
      repeat (4) tick();
      check("stream_dec_cnt", dcnt - d0, 16);
      check("stream_v_cnt", vcnt - v0, 16);
      check("stream_sb_empty", sb.size(), 0);

      // Stall counter saturation.
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      credits_avail_i = 1'b0;
      tick();
      v_i = 1'b1;
      data_i = 32'h77;
      tick();
      v_i = 1'b0;
      repeat (20) tick();
      check("stall_sat", stall_cnt_o, 15);
      tick();
      check("stall_sat_hold", stall_cnt_o, 15);
      credits_avail_i = 1'b1;
      repeat (3) tick();
      check("sat_sb_empty", sb.size(), 0);

      // Asynchronous reset mid-stream with flits buffered.
      credits_avail_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v_i = 1'b1;
         data_i = 32'hDEAD_0000 + i;
         tick();
      end
      v_i = 1'b0;
      credits_avail_i = 1'b1;
      tick();
      check("pre_rst_v", v_o, 1);
      check("pre_rst_dec", dec_credit_o, 1);
      #1;
      reset_i = 1'b1;
      #1;
      check("async_rst_v", v_o, 0);
      check("async_rst_dec", dec_credit_o, 0);
      check("async_rst_ready", ready_o, 0);
      tick();
      reset_i = 1'b0;
      #1;
      check("post_rst_empty", empty_o, 1);
      check("post_rst_dec", dec_credit_o, 0);
      d0 = vcnt;
      repeat (6) tick();
      check("post_rst_no_stale", vcnt - d0, 0);
      check("post_rst_stall", stall_cnt_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
